tog_hs_rx: RTL and testbench
============================

Name: tog_hs_rx

Overview:
- Receiving end of a two-phase (toggle) request/acknowledge link.
- The sender signals each new word by flipping a T-flip-flop-driven `req_tog` line while holding `req_data` stable.
- This block synchronises `req_tog`, detects each flip and presents the captured word on a valid/ready port to local logic.
- When the word is consumed, it returns acknowledgement by flipping its own `ack_tog` flip-flop. It sits at the destination side of any toggle-signalled link in the design.

Parameters:
- DW, 8, width of `req_data` / `out_data`.
- SYNC_STAGES, 2, flops in the `req_tog` synchroniser chain (legal range 2..4).
- CW, 8, width of the event counter `evt_count`.

Ports:
- clk  input  1  single clock for all state.
- rst  input  1  asynchronous reset, active-low (0 = reset); assertion is asynchronous, release is synchronous to clk. The sender is in the same reset domain.
- req_tog  input  1  request toggle from the sender; asynchronous to clk. Each level change means one new word.
- req_data  input  DW  word from the sender; held stable from the `req_tog` flip until the matching `ack_tog` flip.
- ack_tog  output  1  acknowledge toggle; flips once per consumed word.
- out_valid  output  1  captured word available.
- out_data  output  DW  captured word; stable while `out_valid`=1.
- out_ready  input  1  local consumer accepts `out_data` when `out_valid`&&`out_ready` at a clk edge.
- evt_count  output  CW  count of words accepted; wraps modulo 2^CW.
- err  output  1  sticky overrun flag.
- clr_err  input  1  synchronous clear of `err`.

Behaviour:
- Reset (rst=0): sync chain=0, req_prev=0, `ack_tog`=0, `out_valid`=0, `out_data`=0, `evt_count`=0, `err`=0, prime counter=0, state=PRIME. Reset asserted mid-transfer discards the pending word with no ack.
- Synchroniser: `req_tog` → s[0] → … → s[SYNC_STAGES-1] = req_sync; shifts every clk.
- req_prev <= req_sync every clk, in all states.
- edge = req_sync ^ req_prev (combinational).
- State PRIME:
  - Ignore edge; count SYNC_STAGES+1 cycles.
  - Then go to IDLE.
  - Purpose: a `req_tog` level left at 1 across reset never generates a spurious word.
- State IDLE:
  - On edge: `out_data` <= `req_data`, `out_valid` <= 1, go to HOLD.
  - Otherwise hold.
- State HOLD:
  - If `out_ready`=1: `out_valid` <= 0, `ack_tog` <= ~`ack_tog`, `evt_count` <= `evt_count`+1 (wraps), go to IDLE.
  - If edge=1 in HOLD: protocol overrun. `err` <= 1, the new word is dropped, and `out_data` is not overwritten. The event is not queued.
- Latency: `req_tog` flips before edge k → req_sync flips after edge k+SYNC_STAGES-1 → `out_valid`=1 after edge k+SYNC_STAGES. With SYNC_STAGES=2 and `out_ready` held 1, `out_valid` is high exactly one cycle and `ack_tog` flips one edge after `out_valid` rises.
- Back-to-back operation: an edge arriving in the same cycle as the HOLD→IDLE acceptance counts as overrun, because the state is HOLD during that cycle. A compliant sender cannot produce this, since it waits for `ack_tog`.
- `clr_err`: `err` <= 0 unless an overrun is set in the same cycle; set wins.
- `out_valid` never drops without acceptance; `out_data` changes only on capture.
- Both `req_tog` directions (0→1, 1→0) are equal events.

Decomposition:
- Shared package/header:
  - State encoding localparams: ST_PRIME=2'd0, ST_IDLE=2'd1, ST_HOLD=2'd2.
  - Default DW, SYNC_STAGES, CW.
  - Reused by the matching transmitter.
- One sub-module: `bit_sync` (SYNC_STAGES-deep single-bit synchroniser, async active-low reset to 0). Instantiated once for `req_tog`; reused by the transmitter for `ack_tog`.

Test Plan:
- Reset then hold `req_tog`=1 through and after reset release, for 20 cycles → `out_valid` stays 0, `evt_count`=0, `ack_tog`=0, `err`=0.
- After PRIME: `req_data`=8'hA5, flip `req_tog` 0→1, `out_ready`=1 → `out_valid`=1 exactly 2 edges later for 1 cycle with `out_data`=8'hA5; `ack_tog` 0→1 on the next edge; `evt_count`=1.
- Hold `out_ready`=0 after a flip carrying 8'h3C for 10 cycles → `out_valid` and `out_data`=8'h3C stable; `ack_tog` unchanged. Raise `out_ready` → one accept, `ack_tog` flips, `evt_count`+1.
- In HOLD with `out_ready`=0, flip `req_tog` again with `req_data`=8'hFF → `err`=1, `out_data` still 8'h3C. Then pulse `clr_err` → `err`=0; pulse `clr_err` in the same cycle as another overrun edge → `err` stays 1.
- Run 256 compliant handshakes (sender waits for `ack_tog`) with random data and random `out_ready` stalls → all words delivered in order, `evt_count` wraps to 0, `err`=0.
- Assert rst mid-HOLD with `out_valid`=1 → `out_valid`, `ack_tog`, `evt_count` go to 0 immediately (asynchronous). After release, PRIME runs and no word is delivered until the next `req_tog` flip.

Source files
------------

// File: rtl/tog_hs_rx_pkg.sv
// Shared definitions for the toggle-handshake link (receiver and transmitter).
// Holds the state encoding, default widths and the prime-window length helper.
package tog_hs_rx_pkg;

  localparam int DW_DEF          = 8;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int CW_DEF          = 8;

  typedef enum logic [1:0] {
    ST_PRIME = 2'd0,
    ST_IDLE  = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  // Cycles spent ignoring edges after reset so the sync chain and req_prev settle.
  function automatic int prime_len(input int stages);
    return stages + 1;
  endfunction

endpackage

// File: rtl/tog_hs_rx_bit_sync.sv
// Single-bit multi-flop synchroniser; resets to 0.
// Used for req_tog here and for ack_tog on the transmit side.
module bit_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] s;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s <= '0;
    end else begin
      s <= {s[STAGES-2:0], d};
    end
  end

  assign q = s[STAGES-1];

endmodule

// File: rtl/tog_hs_rx.sv
// Receive side of a two-phase toggle link: detects req_tog flips, presents the
// word on a valid/ready port and returns one ack_tog flip per consumed word.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_PRIME | after reset: let the sync chain settle, edges ignored
// ST_IDLE  | waiting for a req_tog flip
// ST_HOLD  | word presented on out_*, waiting for out_ready
module tog_hs_rx
  import tog_hs_rx_pkg::*;
#(
  parameter int DW          = DW_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int CW          = CW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_tog,
  input  logic [DW-1:0] req_data,
  output logic          ack_tog,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  input  logic          out_ready,
  output logic [CW-1:0] evt_count,
  output logic          err,
  input  logic          clr_err
);

  localparam int            PW         = $clog2(SYNC_STAGES + 2);
  localparam logic [PW-1:0] PRIME_LAST = PW'(prime_len(SYNC_STAGES) - 1);

  state_t        state;
  logic [PW-1:0] prime_cnt;
  logic          req_sync;
  logic          req_prev;
  logic          req_edge;

  bit_sync #(
    .STAGES(SYNC_STAGES)
  ) u_req_sync (
    .clk(clk),
    .rst(rst),
    .d  (req_tog),
    .q  (req_sync)
  );

  assign req_edge = req_sync ^ req_prev;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_PRIME;
      prime_cnt <= '0;
      req_prev  <= 1'b0;
      ack_tog   <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      evt_count <= '0;
      err       <= 1'b0;
    end else begin
      req_prev <= req_sync;
      if (clr_err) begin
        err <= 1'b0;
      end
      case (state)
        ST_PRIME: begin
          if (prime_cnt == PRIME_LAST) begin
            prime_cnt <= '0;
            state     <= ST_IDLE;
          end else begin
            prime_cnt <= prime_cnt + 1'b1;
          end
        end
        ST_IDLE: begin
          if (req_edge) begin
            out_data  <= req_data;
            out_valid <= 1'b1;
            state     <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          // A flip while still holding is dropped; the sender broke the handshake.
          if (req_edge) begin
            err <= 1'b1;
          end
          if (out_ready) begin
            out_valid <= 1'b0;
            ack_tog   <= ~ack_tog;
            evt_count <= evt_count + 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_PRIME;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tog_hs_rx.sv
// Directed self-checking bench for tog_hs_rx with default parameters.
module tb_tog_hs_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_tog;
  logic [7:0] req_data;
  logic       ack_tog;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;
  logic [7:0] evt_count;
  logic       err;
  logic       clr_err;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic       exp_ack;
  logic [7:0] exp_evt;

  tog_hs_rx dut (
    .clk      (clk),
    .rst      (rst),
    .req_tog  (req_tog),
    .req_data (req_data),
    .ack_tog  (ack_tog),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_ready(out_ready),
    .evt_count(evt_count),
    .err      (err),
    .clr_err  (clr_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic flip(input logic [7:0] d);
    req_data = d;
    req_tog  = ~req_tog;
  endtask

  task automatic test_reset();
    rst = 1'b0; req_tog = 1'b1; req_data = 8'h00; out_ready = 1'b1; clr_err = 1'b0;
    repeat (3) tick();
    n_tests++;
    if (out_valid !== 1'b0 || ack_tog !== 1'b0 || evt_count !== 8'd0 || err !== 1'b0 || out_data !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_values: valid=%b ack=%b evt=%0d err=%b data=%h, expected all zero",
               out_valid, ack_tog, evt_count, err, out_data);
    end
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      n_tests++;
      if (out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL prime_no_spurious cycle %0d: out_valid=%b expected 0", i, out_valid);
      end
    end
    n_tests++;
    if (evt_count !== 8'd0 || ack_tog !== 1'b0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL prime_end: evt=%0d ack=%b err=%b expected 0 0 0", evt_count, ack_tog, err);
    end
  endtask

  task automatic test_basic();
    rst = 1'b0; req_tog = 1'b0;
    tick(); tick();
    rst = 1'b1;
    repeat (5) tick();
    exp_ack = 1'b0; exp_evt = 8'd0;
    flip(8'hA5);
    for (int i = 0; i < 2; i++) begin
      tick();
      n_tests++;
      if (out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL basic_early edge %0d: out_valid=%b expected 0", i + 1, out_valid);
      end
    end
    tick();
    n_tests++;
    if (out_valid !== 1'b1 || out_data !== 8'hA5 || ack_tog !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_capture: valid=%b data=%h ack=%b expected 1 a5 0", out_valid, out_data, ack_tog);
    end
    tick();
    exp_ack = 1'b1; exp_evt = 8'd1;
    n_tests++;
    if (out_valid !== 1'b0 || ack_tog !== exp_ack || evt_count !== exp_evt) begin
      n_fail++;
      $display("FAIL basic_accept: valid=%b ack=%b evt=%0d expected 0 %b %0d",
               out_valid, ack_tog, evt_count, exp_ack, exp_evt);
    end
  endtask

  task automatic test_stall_overrun();
    out_ready = 1'b0;
    flip(8'h3C);
    repeat (3) tick();
    n_tests++;
    if (out_valid !== 1'b1 || out_data !== 8'h3C) begin
      n_fail++;
      $display("FAIL stall_capture: valid=%b data=%h expected 1 3c", out_valid, out_data);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      n_tests++;
      if (out_valid !== 1'b1 || out_data !== 8'h3C || ack_tog !== exp_ack) begin
        n_fail++;
        $display("FAIL stall_hold cycle %0d: valid=%b data=%h ack=%b expected 1 3c %b",
                 i, out_valid, out_data, ack_tog, exp_ack);
      end
    end
    // Overrun: new flip while the 3C word is still held
    flip(8'hFF);
    tick(); tick();
    n_tests++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL overrun_early: err=%b expected 0", err);
    end
    tick();
    n_tests++;
    if (err !== 1'b1 || out_data !== 8'h3C || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL overrun_set: err=%b data=%h valid=%b expected 1 3c 1", err, out_data, out_valid);
    end
    clr_err = 1'b1; tick(); clr_err = 1'b0;
    n_tests++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_err: err=%b expected 0", err);
    end
    flip(8'h77);
    tick(); tick();
    clr_err = 1'b1; tick(); clr_err = 1'b0;
    n_tests++;
    if (err !== 1'b1 || out_data !== 8'h3C) begin
      n_fail++;
      $display("FAIL set_beats_clr: err=%b data=%h expected 1 3c", err, out_data);
    end
    clr_err = 1'b1; tick(); clr_err = 1'b0;
    n_tests++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_err_2: err=%b expected 0", err);
    end
    out_ready = 1'b1;
    tick();
    exp_ack = ~exp_ack; exp_evt = exp_evt + 8'd1;
    n_tests++;
    if (out_valid !== 1'b0 || ack_tog !== exp_ack || evt_count !== exp_evt) begin
      n_fail++;
      $display("FAIL stall_accept: valid=%b ack=%b evt=%0d expected 0 %b %0d",
               out_valid, ack_tog, evt_count, exp_ack, exp_evt);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      n_tests++;
      if (out_valid !== 1'b0 || ack_tog !== exp_ack) begin
        n_fail++;
        $display("FAIL no_queued_word cycle %0d: valid=%b ack=%b expected 0 %b", i, out_valid, ack_tog, exp_ack);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] d;
    logic       prev;
    int         got;
    rst = 1'b0; tick(); rst = 1'b1;
    repeat (5) tick();
    for (int i = 0; i < 256; i++) begin
      d = 8'($urandom);
      flip(d);
      prev = ack_tog;
      got  = 0;
      for (int c = 0; c < 80 && ack_tog === prev; c++) begin
        out_ready = 1'($urandom_range(0, 1));
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
          got++;
          n_tests++;
          if (out_data !== d) begin
            n_fail++;
            $display("FAIL b2b_data word %0d: got %h expected %h", i, out_data, d);
          end
        end
        tick();
      end
      n_tests++;
      if (ack_tog === prev || got !== 1) begin
        n_fail++;
        $display("FAIL b2b_handshake word %0d: ack=%b prev=%b accepts=%0d expected flip and 1", i, ack_tog, prev, got);
      end
      if (i == 254) begin
        n_tests++;
        if (evt_count !== 8'd255) begin
          n_fail++;
          $display("FAIL b2b_count_255: evt=%0d expected 255", evt_count);
        end
      end
    end
    n_tests++;
    if (evt_count !== 8'd0 || err !== 1'b0 || ack_tog !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_wrap: evt=%0d err=%b ack=%b expected 0 0 0", evt_count, err, ack_tog);
    end
  endtask

  task automatic test_reset_mid();
    logic prev;
    out_ready = 1'b1;
    prev = ack_tog;
    flip(8'h5A);
    for (int c = 0; c < 20 && ack_tog === prev; c++) tick();
    out_ready = 1'b0;
    flip(8'hC3);
    repeat (3) tick();
    n_tests++;
    if (out_valid !== 1'b1 || out_data !== 8'hC3 || evt_count !== 8'd1 || ack_tog !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_pre: valid=%b data=%h evt=%0d ack=%b expected 1 c3 1 1",
               out_valid, out_data, evt_count, ack_tog);
    end
    #2 rst = 1'b0;
    #1;
    n_tests++;
    if (out_valid !== 1'b0 || ack_tog !== 1'b0 || evt_count !== 8'd0 || out_data !== 8'h00) begin
      n_fail++;
      $display("FAIL mid_async_reset: valid=%b ack=%b evt=%0d data=%h expected 0 0 0 00",
               out_valid, ack_tog, evt_count, out_data);
    end
    tick();
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_tests++;
      if (out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL mid_after_release cycle %0d: valid=%b expected 0", i, out_valid);
      end
    end
    flip(8'h96);
    repeat (3) tick();
    n_tests++;
    if (out_valid !== 1'b1 || out_data !== 8'h96) begin
      n_fail++;
      $display("FAIL mid_next_word: valid=%b data=%h expected 1 96", out_valid, out_data);
    end
    out_ready = 1'b1;
    tick();
    n_tests++;
    if (out_valid !== 1'b0 || ack_tog !== 1'b1 || evt_count !== 8'd1) begin
      n_fail++;
      $display("FAIL mid_next_accept: valid=%b ack=%b evt=%0d expected 0 1 1", out_valid, ack_tog, evt_count);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall_overrun();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
